// File: rtl/ej32_pkg.sv
// Shared types and constants for the eJ32 image loader.
// Holds the loader FSM state encoding, frame sync byte and error codes.
// No logic; imported by the loader.
package ej32_pkg;

    typedef enum logic [2:0] {
        L_IDLE,
        L_HDR,
        L_DATA,
        L_CHK,
        L_DONE,
        L_ERR
    } ldr_st;

    localparam logic [7:0] LDR_SYNC    = 8'hA5;

    localparam logic [1:0] LDR_E_NONE  = 2'd0;
    localparam logic [1:0] LDR_E_RANGE = 2'd1;
    localparam logic [1:0] LDR_E_CSUM  = 2'd2;

endpackage

// File: rtl/ej32_img_loader.sv
// Framed byte-stream loader writing the eForth image memory (SYNC, addr, len, data, chk).
// Latency: one cycle from a data byte transfer to its mem_we strobe.
// Backpressure: s_ready stays high while a frame is open; low in DONE/ERR until clr.
module ej32_img_loader
    import ej32_pkg::*;
#(
    parameter int         MEM_SZ = 8192,
    parameter logic [7:0] SYNC   = LDR_SYNC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    input  logic        clr,
    output logic [31:0] mem_a,
    output logic [7:0]  mem_d,
    output logic        mem_we,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err
);

    localparam logic [16:0] MEM_LIM = 17'(MEM_SZ);

    ldr_st       st;
    ldr_st       st_nxt;
    logic [15:0] addr;
    logic [15:0] len;
    logic [15:0] idx;
    logic [1:0]  hdr_cnt;
    logic [7:0]  sum;

    logic        xfer;
    logic [15:0] len_new;
    logic [16:0] end_addr;
    logic        range_bad;
    logic        last_data;
    logic [7:0]  sum_nxt;
    logic [15:0] wr_ofs;

    assign xfer      = s_valid & s_ready;
    assign s_ready   = (st != L_DONE) && (st != L_ERR);
    assign busy      = (st == L_HDR) || (st == L_DATA) || (st == L_CHK);

    // len_hi arrives on the 4th header byte; the range check must use it directly
    assign len_new   = {s_data, len[7:0]};
    assign end_addr  = {1'b0, addr} + {1'b0, len_new};
    assign range_bad = end_addr > MEM_LIM;
    assign last_data = (idx + 16'd1) == len;
    assign sum_nxt   = sum + s_data;
    assign wr_ofs    = addr + idx;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st <= L_IDLE;
        end else begin
            st <= st_nxt;
        end
    end

    // Next-state logic; every move except clr requires a byte transfer
    always_comb begin
        st_nxt = st;
        case (st)
            L_IDLE: begin
                if (xfer && (s_data == SYNC)) begin
                    st_nxt = L_HDR;
                end
            end
            L_HDR: begin
                if (xfer && (hdr_cnt == 2'd3)) begin
                    if (range_bad) begin
                        st_nxt = L_ERR;
                    end else if (len_new == 16'd0) begin
                        st_nxt = L_CHK;
                    end else begin
                        st_nxt = L_DATA;
                    end
                end
            end
            L_DATA: begin
                if (xfer && last_data) begin
                    st_nxt = L_CHK;
                end
            end
            L_CHK: begin
                if (xfer) begin
                    st_nxt = (sum_nxt == 8'd0) ? L_DONE : L_ERR;
                end
            end
            L_DONE, L_ERR: begin
                if (clr) begin
                    st_nxt = L_IDLE;
                end
            end
            default: st_nxt = L_IDLE;
        endcase
    end

    // Header capture, data index and running checksum
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr    <= '0;
            len     <= '0;
            idx     <= '0;
            hdr_cnt <= '0;
            sum     <= '0;
        end else if (xfer) begin
            case (st)
                L_IDLE: begin
                    if (s_data == SYNC) begin
                        hdr_cnt <= '0;
                        idx     <= '0;
                        sum     <= '0;
                    end
                end
                L_HDR: begin
                    hdr_cnt <= hdr_cnt + 2'd1;
                    idx     <= '0;
                    case (hdr_cnt)
                        2'd0:    addr[7:0]  <= s_data;
                        2'd1:    addr[15:8] <= s_data;
                        2'd2:    len[7:0]   <= s_data;
                        default: len[15:8]  <= s_data;
                    endcase
                end
                L_DATA: begin
                    idx <= idx + 16'd1;
                    sum <= sum_nxt;
                end
                default: ;
            endcase
        end
    end

    // Registered memory write port and sticky status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_a  <= '0;
            mem_d  <= '0;
            mem_we <= 1'b0;
            done   <= 1'b0;
            err    <= LDR_E_NONE;
        end else begin
            mem_we <= xfer && (st == L_DATA);
            if (xfer && (st == L_DATA)) begin
                // addr+idx is below MEM_SZ after the header range check, so upper bits stay 0
                mem_a <= 32'(wr_ofs);
                mem_d <= s_data;
            end
            if (xfer && (st == L_HDR) && (hdr_cnt == 2'd3) && range_bad) begin
                err <= LDR_E_RANGE;
            end
            if (xfer && (st == L_CHK)) begin
                if (sum_nxt == 8'd0) begin
                    done <= 1'b1;
                end else begin
                    err <= LDR_E_CSUM;
                end
            end
            if (clr && ((st == L_DONE) || (st == L_ERR))) begin
                done <= 1'b0;
                err  <= LDR_E_NONE;
            end
        end
    end

endmodule

// File: tb/tb_ej32_img_loader.sv
// Self-checking bench for ej32_img_loader: directed frame table plus random frames
// checked against a frame-level reference model and a shadow image memory.
module tb_ej32_img_loader;

    logic        clk;
    logic        rst;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        clr;
    logic [31:0] mem_a;
    logic [7:0]  mem_d;
    logic        mem_we;
    logic        busy;
    logic        done;
    logic [1:0]  err;

    ej32_img_loader dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_ready (s_ready),
        .clr     (clr),
        .mem_a   (mem_a),
        .mem_d   (mem_d),
        .mem_we  (mem_we),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  dut_mem [8192];
    logic [7:0]  exp_mem [8192];
    int          we_count = 0;
    int          hi_bad = 0;
    logic [31:0] last_a = '0;
    logic [7:0]  last_d = '0;

    // Shadow of the image memory as written by the DUT
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            dut_mem[mem_a[12:0]] = mem_d;
            we_count++;
            last_a = mem_a;
            last_d = mem_d;
            if (mem_a[31:13] != 19'd0) hi_bad++;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Offer one byte starting at a negedge; returns the outputs seen one cycle after the transfer
    task automatic send_byte(input logic [7:0] b, output logic we, output logic [31:0] a,
                             output logic [7:0] d, output logic bz, output logic ok);
        int t;
        s_valid = 1'b1;
        s_data  = b;
        t = 0;
        while (s_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        ok = 1'b0;
        we = 1'b0; a = '0; d = '0; bz = 1'b0;
        if (s_ready === 1'b1) begin
            @(posedge clk);
            @(negedge clk);
            we = mem_we; a = mem_a; d = mem_d; bz = busy;
            ok = 1'b1;
        end
        s_valid = 1'b0;
    endtask

    // Frame-level reference: sends the consumed part of a frame and checks every post-transfer sample
    task automatic run_frame(input string nm, input logic [7:0] f[$], input int max_gap);
        int addr, len, nsend, we0, bad_we, bad_busy, gap, sm;
        logic in_rng, xd, exp_we, exp_bz, we, bz, ok;
        logic [1:0]  xe;
        logic [31:0] a;
        logic [7:0]  d;
        addr   = {f[2], f[1]};
        len    = {f[4], f[3]};
        in_rng = (addr + len) <= 8192;
        if (!in_rng) begin
            nsend = 5; xd = 1'b0; xe = 2'd1;
        end else begin
            nsend = 6 + len;
            sm = 0;
            for (int i = 0; i <= len; i++) sm += f[5 + i];
            xd = (sm % 256) == 0;
            xe = xd ? 2'd0 : 2'd2;
        end
        we0 = we_count; bad_we = 0; bad_busy = 0;
        for (int k = 0; k < nsend; k++) begin
            gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                if (k > 0 && busy !== 1'b1) bad_busy++;
            end
            send_byte(f[k], we, a, d, bz, ok);
            if (!ok) begin
                check({nm, " transfer_timeout"}, 32'(k), 32'(nsend));
                return;
            end
            exp_we = in_rng && (k >= 5) && (k < 5 + len);
            if (we !== exp_we || (exp_we && (a !== 32'(addr + k - 5) || d !== f[k]))) bad_we++;
            if (exp_we) exp_mem[addr + k - 5] = f[k];
            exp_bz = (k < nsend - 1);
            if (bz !== exp_bz) bad_busy++;
        end
        check({nm, " we_seq_errors"}, 32'(bad_we), 0);
        check({nm, " busy_errors"}, 32'(bad_busy), 0);
        check({nm, " we_pulses"}, 32'(we_count - we0), in_rng ? 32'(len) : 0);
        check({nm, " done"}, done, xd);
        check({nm, " err"}, err, xe);
        check({nm, " s_ready_closed"}, s_ready, 0);
    endtask

    task automatic do_clr(input string nm);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check({nm, " clr_done"}, done, 0);
        check({nm, " clr_err"}, err, 0);
        check({nm, " clr_ready"}, s_ready, 1);
    endtask

    typedef struct {
        int          n;
        logic [7:0]  b [12];
        logic        garbage;
        int          exp_w;
        logic        exp_done;
        logic [1:0]  exp_err;
        logic [31:0] exp_last_a;
        logic [7:0]  exp_last_d;
    } vec_t;

    vec_t vecs [5];

    initial begin
        logic [7:0]  f[$];
        logic [7:0]  gb[$];
        logic        we, bz, ok;
        logic [31:0] a;
        logic [7:0]  d;
        int          w0, addr, len, sm, miss;

        for (int i = 0; i < 8192; i++) begin
            dut_mem[i] = 8'h00;
            exp_mem[i] = 8'h00;
        end

        vecs[0] = '{9, '{8'hA5,8'h00,8'h10,8'h03,8'h00,8'h11,8'h22,8'h33,8'h9A,8'h00,8'h00,8'h00},
                    1'b0, 3, 1'b1, 2'd0, 32'h1002, 8'h33};
        vecs[1] = '{9, '{8'hA5,8'h00,8'h10,8'h03,8'h00,8'h11,8'h22,8'h33,8'h9B,8'h00,8'h00,8'h00},
                    1'b0, 3, 1'b0, 2'd2, 32'h1002, 8'h33};
        vecs[2] = '{5, '{8'hA5,8'hFE,8'h1F,8'h04,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
                    1'b0, 0, 1'b0, 2'd1, 32'h0, 8'h00};
        vecs[3] = '{9, '{8'hA5,8'hFD,8'h1F,8'h03,8'h00,8'h01,8'h02,8'h03,8'hFA,8'h00,8'h00,8'h00},
                    1'b0, 3, 1'b1, 2'd0, 32'h1FFF, 8'h03};
        vecs[4] = '{6, '{8'hA5,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
                    1'b1, 0, 1'b1, 2'd0, 32'h0, 8'h00};

        rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; clr = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset s_ready", s_ready, 1);
        check("reset mem_we", mem_we, 0);
        check("reset mem_a", mem_a, 0);
        check("reset mem_d", mem_d, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset err", err, 0);

        // Directed frame table
        for (int i = 0; i < 5; i++) begin
            if (vecs[i].garbage) begin
                gb = '{8'h00, 8'h5A, 8'hFF};
                miss = 0;
                foreach (gb[j]) begin
                    send_byte(gb[j], we, a, d, bz, ok);
                    if (!ok || we !== 1'b0 || bz !== 1'b0 || s_ready !== 1'b1) miss++;
                end
                check($sformatf("vec%0d garbage_dropped", i), 32'(miss), 0);
            end
            f = {};
            for (int j = 0; j < vecs[i].n; j++) f.push_back(vecs[i].b[j]);
            w0 = we_count;
            run_frame($sformatf("vec%0d", i), f, 0);
            check($sformatf("vec%0d table_writes", i), 32'(we_count - w0), 32'(vecs[i].exp_w));
            check($sformatf("vec%0d table_done", i), done, vecs[i].exp_done);
            check($sformatf("vec%0d table_err", i), err, vecs[i].exp_err);
            if (vecs[i].exp_w > 0) begin
                check($sformatf("vec%0d last_a", i), last_a, vecs[i].exp_last_a);
                check($sformatf("vec%0d last_d", i), last_d, vecs[i].exp_last_d);
            end
            if (i == 1) begin
                // Bytes offered while closed must not be consumed
                w0 = we_count;
                s_valid = 1'b1; s_data = 8'hA5;
                repeat (3) @(negedge clk);
                s_valid = 1'b0;
                check("closed s_ready", s_ready, 0);
                check("closed err_held", err, 2);
                check("closed no_writes", 32'(we_count - w0), 0);
            end
            do_clr($sformatf("vec%0d", i));
        end

        // Reset after 2 of 3 data bytes: mem_we drops asynchronously, no rollback
        f = '{8'hA5, 8'h00, 8'h10, 8'h03, 8'h00, 8'h11, 8'h22};
        foreach (f[k]) send_byte(f[k], we, a, d, bz, ok);
        exp_mem[16'h1000] = 8'h11;
        exp_mem[16'h1001] = 8'h22;
        check("midrst we_before", we, 1);
        #2 rst = 1'b1;
        #1;
        check("midrst mem_we", mem_we, 0);
        check("midrst busy", busy, 0);
        check("midrst s_ready", s_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        f = '{8'hA5, 8'h00, 8'h10, 8'h03, 8'h00, 8'h44, 8'h55, 8'h66, 8'h09};
        run_frame("after_rst", f, 0);
        do_clr("after_rst");

        // Random frames with valid gaps: full image, short ones, range and checksum errors
        for (int r = 0; r < 4; r++) begin
            len  = (r == 0) ? 3400 : $urandom_range(0, 200);
            addr = (r == 0) ? $urandom_range(0, 8192 - 3400) :
                   (r == 2) ? 8192 - len + 1 + $urandom_range(0, 100) :
                              $urandom_range(0, 8192 - len);
            f = {8'hA5, 8'(addr), 8'(addr >> 8), 8'(len), 8'(len >> 8)};
            sm = 0;
            for (int k = 0; k < len; k++) begin
                f.push_back(8'($urandom));
                sm += f[5 + k];
            end
            f.push_back(8'(256 - (sm % 256)) + ((r == 3) ? 8'd1 : 8'd0));
            run_frame($sformatf("rand%0d", r), f, 3);
            do_clr($sformatf("rand%0d", r));
        end

        miss = 0;
        for (int i = 0; i < 8192; i++) if (dut_mem[i] !== exp_mem[i]) miss++;
        check("image_mismatched_bytes", 32'(miss), 0);
        check("mem_a_high_bits", 32'(hi_bad), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
